operand_stage_fifo: RTL and testbench

- Upstream operand staging stage for the adder/compare datapath (consumer computes op1+op2-3 and drives out).
- Accepts operand pairs plus a select code over a valid/ready handshake and buffers them in a small register FIFO.
- Presents the oldest entry as op1/op2/sel to the consumer, decoupling producer stalls from the combinational datapath.

---
 rtl/operand_stage_fifo.sv | 100 ++++++++++
 tb/tb_operand_stage_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage_fifo.sv
// Purpose: register FIFO staging operand pairs + select code for the adder/compare consumer.
// Latency: 1 cycle push-to-head, no bypass; head is registered state, zeroed while empty.
// Backpressure: in_ready drops when full (no pass-through on simultaneous pop); head holds until out_ready.
// Optional: define OPSTAGE_DROP_CNT_EN to add the saturating drop_cnt output.
module operand_stage_fifo #(
  parameter int DW    = 8,
  parameter int SW    = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [SW-1:0] sel_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] op1,
  output logic [DW-1:0] op2,
  output logic [SW-1:0] sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count
`ifdef OPSTAGE_DROP_CNT_EN
  ,output logic [15:0]  drop_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [SW-1:0] s;
  } entry_t;

  // Full level expressed at count width so the compare is width-exact.
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake flags come only from occupancy, never from the opposite side's handshake.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head presented directly from storage; forced to zero when nothing is buffered.
  assign op1 = out_valid ? mem[rd_ptr].a : '0;
  assign op2 = out_valid ? mem[rd_ptr].b : '0;
  assign sel = out_valid ? mem[rd_ptr].s : '0;

  // Pointer, occupancy and storage update; flush discards same-cycle push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{a: in1, b: in2, s: sel_in};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef OPSTAGE_DROP_CNT_EN
  // Counts cycles where the producer offered data but was refused; sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_stage_fifo.sv
// Bench for operand_stage_fifo: directed scenarios plus random traffic against a queue model.
// Outputs are checked at the falling edge; inputs change 1 ns after the rising edge.
// Build with OPSTAGE_DROP_CNT_EN defined to also exercise drop_cnt.
module tb_operand_stage_fifo;
  localparam int DW    = 8;
  localparam int SW    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic [SW-1:0] sel_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [SW-1:0] sel;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
`ifdef OPSTAGE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  operand_stage_fifo #(.DW(DW), .SW(SW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in1       (in1),
    .in2       (in2),
    .sel_in    (sel_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef OPSTAGE_DROP_CNT_EN
    ,.drop_cnt (drop_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [SW-1:0] s;
  } ent_t;

  // Reference model: an ordered list of buffered pairs plus a drop tally.
  ent_t q[$];
  int   m_drop = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    ent_t h = '0;
    if (q.size() > 0) h = q[0];
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    chk("count",     32'(count),     32'(q.size()));
    chk("op1",       32'(op1),       32'(h.a));
    chk("op2",       32'(op2),       32'(h.b));
    chk("sel",       32'(sel),       32'(h.s));
`ifdef OPSTAGE_DROP_CNT_EN
    chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
`endif
  endtask

  // One clock: check at falling edge, apply model rules at the rising edge.
  task automatic tick();
    bit was_full, do_push, do_pop;
    @(negedge clk);
    check_state();
    was_full = (q.size() == DEPTH);
    do_push  = in_valid && !was_full;
    do_pop   = out_ready && (q.size() != 0);
    @(posedge clk);
    if (!rst || flush) begin
      q.delete();
      m_drop = 0;
    end else begin
      if (in_valid && was_full && m_drop < 65535) m_drop++;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ent_t'{a: in1, b: in2, s: sel_in});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [SW-1:0] s, input logic r);
    in_valid  = v;
    in1       = a;
    in2       = b;
    sel_in    = s;
    out_ready = r;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  initial begin
    int expect_k;
    int cyc;
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    check_state();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Reset held with a producer pushing: nothing may enter.
    drive(1'b1, 8'h21, 8'h22, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_hold_count", 32'(count), 32'd0);

    // First push after release appears one cycle later.
    rst = 1'b1;
    tick();
    chk("first_vld", 32'(out_valid), 32'd1);
    chk("first_op1", 32'(op1), 32'h21);
    drain();

    // Single pass.
    drive(1'b1, 8'h10, 8'h05, 2'b01, 1'b0);
    tick();
    chk("single_op1", 32'(op1), 32'h10);
    chk("single_op2", 32'(op2), 32'h05);
    chk("single_sel", 32'(sel), 32'h1);
    chk("single_cnt", 32'(count), 32'd1);
    drive(1'b0, '0, '0, '0, 1'b1);
    tick();
    chk("single_pop_cnt", 32'(count), 32'd0);

    // Fill to full, refused fifth push, ordered drain.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(2*k+1), 8'(2*k+2), 2'(k), 1'b0);
      tick();
    end
    chk("full_cnt", 32'(count), 32'd4);
    chk("full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, 8'd9, 8'd10, 2'd0, 1'b0);
    tick();
    chk("full_refuse_cnt", 32'(count), 32'd4);
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("fill_head", 32'(op1), 32'(2*k+1));
      tick();
    end
    chk("fill_empty_vld", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count=2, then at full.
    drive(1'b1, 8'h31, 8'h32, 2'd1, 1'b0); tick();
    drive(1'b1, 8'h33, 8'h34, 2'd2, 1'b0); tick();
    drive(1'b1, 8'hAA, 8'h55, 2'd3, 1'b1); tick();
    chk("simul_cnt", 32'(count), 32'd2);
    chk("simul_head", 32'(op1), 32'h33);
    drive(1'b0, '0, '0, '0, 1'b1); tick();
    chk("simul_new_head", 32'(op1), 32'hAA);
    drain();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h40 + k), 8'(k), 2'(k), 1'b0);
      tick();
    end
    drive(1'b1, 8'h77, 8'h78, 2'd1, 1'b1);
    tick();
    chk("full_simul_cnt", 32'(count), 32'd3);
    drain();

    // Stream 10 pairs with out_ready toggling; producer holds until accepted.
    expect_k = 0;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(k), 8'(k+1), 2'(k), 1'(cyc));
      while (!in_ready && cyc < 200) begin
        tick();
        cyc++;
        out_ready = 1'(cyc);
      end
      tick();
      cyc++;
      out_ready = 1'(cyc);
    end
    chk("stream_budget", 32'(cyc < 200), 32'd1);
    drain();

    // Flush with three entries buffered.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h60 + k), 8'h01, 2'd0, 1'b0);
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 8'h99, 8'h99, 2'd2, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_vld", 32'(out_valid), 32'd0);
    tick();

`ifdef OPSTAGE_DROP_CNT_EN
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(k), 8'(k), 2'd0, 1'b0);
      tick();
    end
    for (int k = 0; k < 6; k++) tick();
    chk("drop_six", 32'(drop_cnt), 32'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drop_flush", 32'(drop_cnt), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
`endif

    // Asynchronous reset mid-transfer, checked with no clock edge in between.
    drive(1'b1, 8'hC1, 8'hC2, 2'd1, 1'b0); tick();
    drive(1'b1, 8'hC3, 8'hC4, 2'd2, 1'b0); tick();
    #2;
    rst = 1'b0;
    q.delete();
    m_drop = 0;
    #1;
    check_state();
    chk("async_op1", 32'(op1), 32'd0);
    tick();
    rst = 1'b1;

    // Random traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            2'($urandom), 1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;
    drain();
    check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
